spi_master: RTL

Parametrised SPI master: the next generation of our single-channel SPI block. It generalises data width, SCLK rate and chip-select count, and adds runtime-selectable SPI mode (CPOL/CPHA) and bit order. It also has a proper start/ready/rx_valid handshake and true full-duplex shifting. It sits between on-chip logic (the host side) and external SPI slaves, driving sclk, mosi and one active-low chip select per slave.

---
 rtl/spi_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: parametrised full-duplex SPI master with runtime
// CPOL/CPHA and bit order, one active-low select per slave.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 1,
  localparam int CS_SEL_W  = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CS_SEL_W-1:0]   cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_CS-1:0]     cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);

  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEAD  = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] TRAIL = 2'd3;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [EDGE_W-1:0]     edge_nxt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_first_sh;
  logic                  tx_bit;
  logic                  tx_first_bit;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  lsb_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic [NUM_CS-1:0]     cs_n_q;
  logic                  sel_ok;
  logic                  accept;
  logic                  half_end;
  logic                  toggle;
  logic                  lead_edge;
  logic                  do_shift;
  logic                  do_sample;

  assign ready = (state == IDLE);
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign cs_n  = cs_n_q;

  always_comb begin
    sel_ok   = int'(cs_sel) < NUM_CS;
    accept   = start && ready && sel_ok;
    half_end = (div_cnt == DIV_LAST);
    edge_nxt = edge_cnt + 1'b1;
    // LEAD ends with edge 1; the last XFER half-period has no edge
    toggle = half_end &&
             ((state == LEAD) ||
              ((state == XFER) && (edge_cnt != EDGE_LAST)));
    lead_edge = edge_nxt[0];
    do_shift  = toggle &&
                (cpha_q ? lead_edge
                        : (!lead_edge && (edge_nxt != EDGE_LAST)));
    do_sample = toggle && (cpha_q ? !lead_edge : lead_edge);
    tx_bit  = lsb_q ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
    tx_next = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
    rx_next = lsb_q ? {miso, rx_sh[DATA_WIDTH-1:1]}
                    : {rx_sh[DATA_WIDTH-2:0], miso};
    tx_first_bit = lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
    tx_first_sh  = lsb_first ? (tx_data >> 1) : (tx_data << 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= '1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= half_end ? '0 : div_cnt + 1'b1;
      end
      if (toggle) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_nxt;
      end
      if (do_shift) begin
        mosi_q <= tx_bit;
        tx_sh  <= tx_next;
      end
      if (do_sample) begin
        rx_sh <= rx_next;
      end
      unique case (state)
        IDLE: begin
          sclk_q   <= cpol;
          mosi_q   <= 1'b0;
          cs_n_q   <= '1;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (accept) begin
            state  <= LEAD;
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            rx_sh  <= '0;
            cs_n_q <= ~(NUM_CS'(1) << cs_sel);
            // CPHA=0 needs the first bit valid before edge 1
            if (!cpha) begin
              mosi_q <= tx_first_bit;
              tx_sh  <= tx_first_sh;
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        LEAD: begin
          if (half_end) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (half_end && (edge_cnt == EDGE_LAST)) begin
            state <= TRAIL;
          end
        end
        TRAIL: begin
          if (half_end) begin
            state    <= IDLE;
            cs_n_q   <= '1;
            mosi_q   <= 1'b0;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
